// File: rtl/bus85_defs.sv
// Shared definitions for the 8085-style bus interface unit: bus state encoding,
// {IOM_,S1,S0} cycle-type codes and default bus widths.
// Optional feature macro: BUS85_HOLD_EN adds the HOLDS state (HOLD/HLDA handover).
package bus85_defs;

   localparam int DATASIZE_DEF = 8;
   localparam int ADDRSIZE_DEF = 16;

`ifdef BUS85_HOLD_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_T1    = 3'd1,
      ST_T2    = 3'd2,
      ST_TW    = 3'd3,
      ST_T3    = 3'd4,
      ST_HOLDS = 3'd5
   } bus85_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_T1    = 3'd1,
      ST_T2    = 3'd2,
      ST_TW    = 3'd3,
      ST_T3    = 3'd4
   } bus85_state_t;
`endif

   // {IOM_, S1, S0} per machine-cycle type
   localparam logic [2:0] CYC_MEM_RD = 3'b010;
   localparam logic [2:0] CYC_MEM_WR = 3'b001;
   localparam logic [2:0] CYC_IO_RD  = 3'b110;
   localparam logic [2:0] CYC_IO_WR  = 3'b101;
   localparam logic [2:0] CYC_INTA   = 3'b111;

   // Interrupt acknowledge overrides the write and I/O selects.
   function automatic logic [2:0] cyc_type(input logic wr, input logic io, input logic inta);
      if (inta)
         return CYC_INTA;
      else if (io)
         return wr ? CYC_IO_WR : CYC_IO_RD;
      else
         return wr ? CYC_MEM_WR : CYC_MEM_RD;
   endfunction

endpackage

// File: rtl/bus85_waitgen.sv
// Wait-state generator: counts TW cycles of the current transfer, holds off
// READY until FIXED_WAIT TW cycles have elapsed and flags a timeout once
// WAIT_MAX TW cycles have passed without READY (WAIT_MAX = 0 waits forever).
module bus85_waitgen #(
   parameter int WAIT_MAX   = 15,
   parameter int FIXED_WAIT = 0
) (
   input  logic CLK,
   input  logic RST_,
   input  logic i_active,   // bus is in T2 or TW: this edge decides T3 vs TW
   input  logic i_ready,
   output logic o_go_t3,
   output logic o_tmo
);

   localparam int MAXV = (WAIT_MAX > FIXED_WAIT) ? WAIT_MAX : FIXED_WAIT;
   localparam int CW   = $clog2(MAXV + 2);
   localparam logic [CW-1:0] FW = CW'(FIXED_WAIT);
   localparam logic [CW-1:0] WM = CW'(WAIT_MAX);

   logic [CW-1:0] r_cnt;
   logic          w_fixed_done;

   assign w_fixed_done = (r_cnt >= FW);
   // READY wins over the timeout when both would apply on the same edge.
   assign o_go_t3 = i_active && w_fixed_done && i_ready;
   assign o_tmo   = i_active && !o_go_t3 && (WAIT_MAX != 0) && (r_cnt >= WM);

   // Count inserted TW cycles; cleared whenever the bus is not deciding.
   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_)
         r_cnt <= '0;
      else if (!i_active)
         r_cnt <= '0;
      else if (!o_go_t3 && !o_tmo && (r_cnt != '1))
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/bus_unit85.sv
// 8085-style external bus interface unit: turns a held internal request into a
// multiplexed T1/T2/[TW..]/T3 bus cycle and returns a one-cycle ack (with err
// when the wait timed out). All pin outputs are decoded from registered state.
// Optional feature macro: BUS85_HOLD_EN enables HOLD/HLDA bus handover.
module bus_unit85
   import bus85_defs::*;
#(
   parameter int DATASIZE   = DATASIZE_DEF,
   parameter int ADDRSIZE   = ADDRSIZE_DEF,
   parameter int WAIT_MAX   = 15,
   parameter int FIXED_WAIT = 0
) (
   input  logic                         CLK,
   input  logic                         RST_,
   input  logic                         req,
   input  logic                         req_wr,
   input  logic                         req_io,
   input  logic                         req_inta,
   input  logic [ADDRSIZE-1:0]          req_addr,
   input  logic [DATASIZE-1:0]          req_data,
   output logic [DATASIZE-1:0]          rd_data,
   output logic                         ack,
   output logic                         err,
   inout  wire  [DATASIZE-1:0]          ADDRDATA,
   output wire  [ADDRSIZE-DATASIZE-1:0] ADDR,
   output logic                         ALE,
   output wire                          RD_,
   output wire                          WR_,
   output logic                         INTA_,
   output wire                          IOM_,
   output logic                         S1,
   output logic                         S0,
   input  logic                         READY,
   input  logic                         HOLD,
   output logic                         HLDA,
   output logic [2:0]                   o_dbg_state
);

   // Handshake: req is a level held with req_* stable; it is taken only in IDLE
   // when no ack is being shown, and ack pulses for one cycle after T3.

   bus85_state_t          r_state;
   logic [2:0]            r_type;
   logic [ADDRSIZE-1:0]   r_addr;
   logic [DATASIZE-1:0]   r_data;
   logic [DATASIZE-1:0]   r_rd_data;
   logic                  r_tmo_flag;
   logic                  r_ack;
   logic                  r_err;

   logic                  w_active;
   logic                  w_bus_cyc;
   logic                  w_strobe;
   logic                  w_go_t3;
   logic                  w_tmo;
   logic                  w_float;
   logic                  w_hold_req;
   logic [2:0]            w_status;

   assign w_active  = (r_state == ST_T2) || (r_state == ST_TW);
   assign w_strobe  = w_active || (r_state == ST_T3);
   assign w_bus_cyc = w_strobe || (r_state == ST_T1);

`ifdef BUS85_HOLD_EN
   assign w_float    = (r_state == ST_HOLDS);
   assign w_hold_req = HOLD;
`else
   logic w_unused_hold;
   assign w_unused_hold = HOLD;
   assign w_float       = 1'b0;
   assign w_hold_req    = 1'b0;
`endif

   bus85_waitgen #(
      .WAIT_MAX   (WAIT_MAX),
      .FIXED_WAIT (FIXED_WAIT)
   ) u_waitgen (
      .CLK      (CLK),
      .RST_     (RST_),
      .i_active (w_active),
      .i_ready  (READY),
      .o_go_t3  (w_go_t3),
      .o_tmo    (w_tmo)
   );

   // Bus cycle sequencer: state, latched request, read capture and ack/err pulses.
   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         r_state    <= ST_IDLE;
         r_type     <= 3'b000;
         r_addr     <= '0;
         r_data     <= '0;
         r_rd_data  <= '0;
         r_tmo_flag <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_hold_req) begin
`ifdef BUS85_HOLD_EN
                  r_state <= ST_HOLDS;
`endif
               end else if (req && !r_ack) begin
                  r_state    <= ST_T1;
                  r_type     <= cyc_type(req_wr, req_io, req_inta);
                  r_addr     <= req_addr;
                  r_data     <= req_data;
                  r_tmo_flag <= 1'b0;
               end
            end
            ST_T1: r_state <= ST_T2;
            ST_T2, ST_TW: begin
               if (w_go_t3) begin
                  r_state <= ST_T3;
               end else if (w_tmo) begin
                  r_state    <= ST_T3;
                  r_tmo_flag <= 1'b1;
               end else begin
                  r_state <= ST_TW;
               end
            end
            ST_T3: begin
               r_state <= ST_IDLE;
               r_ack   <= 1'b1;
               r_err   <= r_tmo_flag;
               // S1=1 marks read and interrupt-acknowledge cycles
               if (r_type[1])
                  r_rd_data <= ADDRDATA;
            end
`ifdef BUS85_HOLD_EN
            ST_HOLDS: begin
               if (!HOLD)
                  r_state <= ST_IDLE;
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_status = w_bus_cyc ? r_type : 3'b000;

   assign ALE   = (r_state == ST_T1);
   assign S1    = w_status[1];
   assign S0    = w_status[0];
   assign INTA_ = !(w_strobe && (r_type == CYC_INTA));
   assign HLDA  = w_float;

   assign IOM_ = w_float ? 1'bz : w_status[2];
   assign RD_  = w_float ? 1'bz : !(w_strobe && (r_type[1:0] == 2'b10));
   assign WR_  = w_float ? 1'bz : !(w_strobe && (r_type[1:0] == 2'b01));

   // Address pins only during T1..T3; AD carries the low address in T1 and
   // write data in T2..T3. Read cycles never drive AD after T1.
   assign ADDR     = w_bus_cyc ? r_addr[ADDRSIZE-1:DATASIZE] : 'z;
   assign ADDRDATA = (r_state == ST_T1)                   ? r_addr[DATASIZE-1:0] :
                     (w_strobe && (r_type[1:0] == 2'b01)) ? r_data               : 'z;

   assign rd_data     = r_rd_data;
   assign ack         = r_ack;
   assign err         = r_err;
   assign o_dbg_state = r_state;

endmodule
